// File: rtl/v3_trap_filter_pkg.sv
// v3_param: shared constants, config width helper and FSM state
// encoding for the v3 trapezoidal filter channel.
package v3_param;

  localparam int IN_W_DEF   = 16;
  localparam int OUT_W_DEF  = 16;
  localparam int ACC_W_DEF  = 48;
  localparam int M_W_DEF    = 16;
  localparam int MAX_KL_DEF = 256;
  localparam int SHIFT_DEF  = 7;
  localparam int K_DEF_DEF  = 4;
  localparam int L_DEF_DEF  = 8;
  localparam int M_DEF_DEF  = 0;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    APPLY
  } state_t;

  function automatic int cfg_w(input int max_kl);
    return $clog2(max_kl + 1);
  endfunction

endpackage

// File: rtl/v3_trap_filter_tapline.sv
// v3_tapline: circular sample history with taps at delays k, l, k+l.
// Ports: clk/reset, clear (restart history), wr_en/wr_data, k/l, taps.
module v3_tapline
  import v3_param::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int MAX_KL = MAX_KL_DEF,
  localparam int CFG_W = cfg_w(MAX_KL),
  localparam int PTR_W = (MAX_KL > 1) ? $clog2(MAX_KL) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic signed [IN_W-1:0] wr_data,
  input  logic [CFG_W-1:0]       k,
  input  logic [CFG_W-1:0]       l,
  output logic signed [IN_W-1:0] tap_k,
  output logic signed [IN_W-1:0] tap_l,
  output logic signed [IN_W-1:0] tap_kl
);

  localparam logic [CFG_W:0] DEPTH = (CFG_W+1)'(MAX_KL);

  logic signed [IN_W-1:0] mem [MAX_KL];
  logic [PTR_W-1:0]       wp;
  logic [CFG_W-1:0]       fill;
  logic [CFG_W-1:0]       kl;

  // Slot holding the sample written j accepts before the current one.
  function automatic logic [PTR_W-1:0] slot(
    input logic [PTR_W-1:0] ptr,
    input logic [CFG_W-1:0] j
  );
    logic [CFG_W:0] idx;
    idx = (CFG_W+1)'(ptr) + DEPTH - (CFG_W+1)'(j);
    if (idx >= DEPTH) idx = idx - DEPTH;
    return idx[PTR_W-1:0];
  endfunction

  // Accepted configs never exceed MAX_KL, so no carry is lost.
  assign kl = k + l;

  // Slots beyond the fill count are stale; they read as zero.
  assign tap_k  = (k  <= fill) ? mem[slot(wp, k)]  : '0;
  assign tap_l  = (l  <= fill) ? mem[slot(wp, l)]  : '0;
  assign tap_kl = (kl <= fill) ? mem[slot(wp, kl)] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wp   <= '0;
      fill <= '0;
    end else if (wr_en) begin
      wp <= (wp == PTR_W'(MAX_KL - 1)) ? '0 : wp + 1'b1;
      if (fill != CFG_W'(MAX_KL)) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/v3_trap_filter.sv
// v3_trap_filter: trapezoidal shaper, 5-stage pipeline, runtime k/l/M.
// Ports: in valid/ready/data, cfg load/k/l/m/busy/err, out valid/data/sat.
module v3_trap_filter
  import v3_param::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int M_W    = M_W_DEF,
  parameter int MAX_KL = MAX_KL_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  parameter int K_DEF  = K_DEF_DEF,
  parameter int L_DEF  = L_DEF_DEF,
  parameter int M_DEF  = M_DEF_DEF,
  localparam int CFG_W = cfg_w(MAX_KL)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    cfg_load,
  input  logic [CFG_W-1:0]        cfg_k,
  input  logic [CFG_W-1:0]        cfg_l,
  input  logic [M_W-1:0]          cfg_m,
  output logic                    cfg_busy,
  output logic                    cfg_err,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t HI =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam acc_t LO =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t state, state_nx;

  logic [CFG_W-1:0] k, l, pend_k, pend_l;
  logic [M_W-1:0]   m, pend_m;
  logic             accept, cfg_ok, pipe_busy, apply;

  logic signed [IN_W-1:0] tap_k, tap_l, tap_kl;

  logic v1, v2, v3, v4;
  acc_t d_nx, d1, p, m2, r3, s, s_sh, mz;

  logic signed [OUT_W-1:0] sat_val;
  logic                    sat_hit;

  v3_tapline #(
    .IN_W   (IN_W),
    .MAX_KL (MAX_KL)
  ) u_tap (
    .clk     (clk),
    .reset   (reset),
    .clear   (apply),
    .wr_en   (accept),
    .wr_data (in_data),
    .k       (k),
    .l       (l),
    .tap_k   (tap_k),
    .tap_l   (tap_l),
    .tap_kl  (tap_kl)
  );

  assign accept    = in_valid & in_ready;
  assign pipe_busy = v1 | v2 | v3 | v4;

  assign cfg_ok = (cfg_k != '0) && (cfg_k <= cfg_l) &&
    (({1'b0, cfg_k} + {1'b0, cfg_l}) <= (CFG_W+1)'(MAX_KL));

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    cfg_busy = 1'b0;
    apply    = 1'b0;
    unique case (state)
      RUN: begin
        in_ready = 1'b1;
        // A sample accepted alongside the request still needs draining.
        if (cfg_load && cfg_ok)
          state_nx = (pipe_busy || in_valid) ? DRAIN : APPLY;
      end
      DRAIN: begin
        cfg_busy = 1'b1;
        if (!pipe_busy) state_nx = APPLY;
      end
      APPLY: begin
        apply    = 1'b1;
        state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      k       <= CFG_W'(K_DEF);
      l       <= CFG_W'(L_DEF);
      m       <= M_W'(M_DEF);
      pend_k  <= CFG_W'(K_DEF);
      pend_l  <= CFG_W'(L_DEF);
      pend_m  <= M_W'(M_DEF);
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nx;
      cfg_err <= (state == RUN) && cfg_load && !cfg_ok;
      if ((state == RUN) && cfg_load && cfg_ok) begin
        pend_k <= cfg_k;
        pend_l <= cfg_l;
        pend_m <= cfg_m;
      end
      if (apply) begin
        k <= pend_k;
        l <= pend_l;
        m <= pend_m;
      end
    end
  end

  assign d_nx = acc_t'(in_data) - acc_t'(tap_k)
              - acc_t'(tap_l) + acc_t'(tap_kl);
  assign mz   = {{(ACC_W-M_W){1'b0}}, m};
  assign s_sh = s >>> SHIFT;

  always_comb begin
    sat_hit = 1'b0;
    sat_val = s_sh[OUT_W-1:0];
    if (s_sh > HI) begin
      sat_hit = 1'b1;
      sat_val = HI[OUT_W-1:0];
    end else if (s_sh < LO) begin
      sat_hit = 1'b1;
      sat_val = LO[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      v4        <= 1'b0;
      out_valid <= 1'b0;
      d1        <= '0;
      p         <= '0;
      m2        <= '0;
      r3        <= '0;
      s         <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      v1        <= accept;
      v2        <= v1;
      v3        <= v2;
      v4        <= v3;
      out_valid <= v4;
      if (accept) d1 <= d_nx;
      if (v1) begin
        p  <= p + d1;
        m2 <= d1 * mz;
      end
      if (v2) r3 <= p + m2;
      if (v3) s <= s + r3;
      if (v4) begin
        out_data <= sat_val;
        if (sat_hit) out_sat <= 1'b1;
      end
      if (apply) begin
        p       <= '0;
        s       <= '0;
        out_sat <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_v3_trap_filter.sv
// Scoreboard bench for v3_trap_filter against a queue-based
// reference of the trapezoid recurrence.
module tb_v3_trap_filter;

  localparam int IN_W   = 16;
  localparam int OUT_W  = 16;
  localparam int M_W    = 16;
  localparam int MAX_KL = 256;
  localparam int SHIFT  = 0;
  localparam int CFG_W  = $clog2(MAX_KL + 1);
  localparam longint OHI = (64'sd1 <<< (OUT_W - 1)) - 1;
  localparam longint OLO = -(64'sd1 <<< (OUT_W - 1));

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [IN_W-1:0] in_data = '0;
  logic cfg_load = 1'b0;
  logic [CFG_W-1:0] cfg_k = '0;
  logic [CFG_W-1:0] cfg_l = '0;
  logic [M_W-1:0] cfg_m = '0;
  logic cfg_busy, cfg_err, out_valid, out_sat;
  logic signed [OUT_W-1:0] out_data;

  always #5 clk = ~clk;

  v3_trap_filter #(.SHIFT(SHIFT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cfg_load  (cfg_load),
    .cfg_k     (cfg_k),
    .cfg_l     (cfg_l),
    .cfg_m     (cfg_m),
    .cfg_busy  (cfg_busy),
    .cfg_err   (cfg_err),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_cyc = 0;
  int acc_cyc = 0;

  typedef struct {
    int data;
    bit sat;
  } exp_t;

  exp_t   expq[$];
  exp_t   mon_e;
  int     seen[$];
  int     want[$];
  int     hist[$];
  longint mp, ms;
  int     mk = 4, ml = 8, mm = 0;
  bit     msat = 1'b0;
  logic signed [OUT_W-1:0] last_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint past(input int j);
    if (j > hist.size()) return 0;
    return hist[hist.size() - j];
  endfunction

  function automatic void model_accept(input int x);
    longint d, o;
    d  = x - past(mk) - past(ml) + past(mk + ml);
    mp = mp + d;
    ms = ms + mp + longint'(mm) * d;
    o  = ms >>> SHIFT;
    if (o > OHI) begin
      o = OHI; msat = 1'b1;
    end else if (o < OLO) begin
      o = OLO; msat = 1'b1;
    end
    expq.push_back('{int'(o), msat});
    hist.push_back(x);
    if (hist.size() > MAX_KL) void'(hist.pop_front());
  endfunction

  function automatic void model_apply(input int k, l, m);
    mk = k; ml = l; mm = m;
    hist.delete();
    mp = 0; ms = 0; msat = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      last_out = '0;
    end else if (out_valid) begin
      if (seen.size() == 0) first_cyc = cyc;
      seen.push_back(int'(out_data));
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0d expected none", out_data);
      end else begin
        mon_e = expq.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_sat", out_sat, mon_e.sat);
      end
      last_out = out_data;
    end else begin
      check("out_hold", out_data, last_out);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      cfg_load = 1'b0;
    end
  endtask

  task automatic send(input int x);
    int n;
    n = 0;
    @(negedge clk);
    cfg_load = 1'b0;
    while (!in_ready && n < 20) begin
      in_valid = 1'b0;
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("send_timeout", n, 0);
      in_valid = 1'b0;
    end else begin
      in_valid = 1'b1;
      in_data  = IN_W'(x);
      model_accept(x);
    end
  endtask

  task automatic cfg(input int k, l, m, input bit ws, input int x,
                     input int exp_low);
    bit ok;
    int low;
    low = 0;
    @(negedge clk);
    while (!in_ready && low < 20) begin
      in_valid = 1'b0;
      low++;
      @(negedge clk);
    end
    ok = (k >= 1) && (k <= l) && (k + l <= MAX_KL);
    cfg_load = 1'b1;
    cfg_k    = CFG_W'(k);
    cfg_l    = CFG_W'(l);
    cfg_m    = M_W'(m);
    in_valid = ws;
    in_data  = IN_W'(x);
    if (ws) model_accept(x);
    if (ok) model_apply(k, l, m);
    @(negedge clk);
    cfg_load = 1'b0;
    in_valid = 1'b0;
    check("cfg_err", cfg_err, !ok);
    if (!ok) begin
      check("err_ready", in_ready, 1);
      @(negedge clk);
      check("err_pulse", cfg_err, 0);
    end else begin
      if (ws) check("cfg_busy", cfg_busy, 1);
      low = 0;
      while (!in_ready && low < 20) begin
        low++;
        @(negedge clk);
      end
      if (exp_low >= 0) check("ready_low", low, exp_low);
      else check("ready_low_range", (low >= 1 && low <= 6), 1);
    end
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_load = 1'b0;
    while (expq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", expq.size(), 0);
    expq.delete();
  endtask

  task automatic check_seq(input string name);
    for (int i = 0; i < want.size(); i++) begin
      if (i < seen.size()) check(name, seen[i], want[i]);
      else check({name, "_missing"}, seen.size(), want.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_apply(4, 8, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_busy", cfg_busy, 0);
    check("rst_err", cfg_err, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sat", out_sat, 0);

    // impulse, k=1 l=2 M=0, plus latency
    cfg(1, 2, 0, 1'b0, 0, 1);
    seen.delete();
    send(1);
    acc_cyc = cyc;
    repeat (7) send(0);
    drain_wait();
    want = '{1, 1, 0, 0, 0, 0, 0, 0};
    check_seq("imp_m0");
    check("latency", first_cyc - acc_cyc, 5);

    // impulse with pole-zero M=2
    cfg(1, 2, 2, 1'b0, 0, 1);
    seen.delete();
    send(1);
    repeat (7) send(0);
    drain_wait();
    want = '{3, 1, -2, 0, 0, 0, 0, 0};
    check_seq("imp_m2");

    // step, back-to-back then with bubbles
    cfg(1, 2, 2, 1'b0, 0, 1);
    seen.delete();
    repeat (6) send(1);
    drain_wait();
    want = '{3, 4, 2, 2, 2, 2};
    check_seq("step");
    cfg(1, 2, 2, 1'b0, 0, 1);
    seen.delete();
    repeat (6) begin
      send(1);
      idle($urandom_range(0, 3));
    end
    drain_wait();
    check_seq("step_bubble");

    // rejected requests leave config and history alone
    cfg(5, 3, 0, 1'b0, 0, -1);
    cfg(300, 10, 0, 1'b0, 0, -1);
    repeat (10) send(int'($urandom_range(0, 200)) - 100);
    drain_wait();

    // saturation at defaults
    cfg(4, 8, 0, 1'b0, 0, 1);
    seen.delete();
    repeat (40) send(32767);
    drain_wait();
    check("sat_peak", seen[seen.size() - 1], OHI);
    check("sat_flag", out_sat, 1);
    idle(10);
    check("sat_sticky", out_sat, 1);
    cfg(1, 2, 0, 1'b0, 0, 1);
    check("sat_clear", out_sat, 0);

    // mid-stream change with a coincident sample
    repeat (5) send(int'($urandom_range(0, 400)) - 200);
    cfg(2, 3, 1, 1'b1, 77, 6);
    repeat (12) send(int'($urandom_range(0, 400)) - 200);
    drain_wait();

    // randomized traffic with occasional reconfiguration
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        cfg($urandom_range(0, 10), $urandom_range(1, 12),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2000)) - 1000, -1);
      end else if (r < 78) begin
        send(int'($urandom_range(0, 2000)) - 1000);
      end else begin
        idle(1);
      end
    end
    drain_wait();

    // reset while draining abandons the pending config
    send(5);
    send(6);
    @(negedge clk);
    cfg_load = 1'b1;
    cfg_k = CFG_W'(2);
    cfg_l = CFG_W'(2);
    cfg_m = M_W'(1);
    in_valid = 1'b1;
    in_data = IN_W'(7);
    model_accept(7);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_k = CFG_W'(5);
    cfg_l = CFG_W'(1);
    check("drain_busy", cfg_busy, 1);
    check("drain_ready", in_ready, 0);
    @(negedge clk);
    cfg_load = 1'b0;
    check("drain_no_err", cfg_err, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    expq.delete();
    model_apply(4, 8, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_ready", in_ready, 1);
    check("rst2_busy", cfg_busy, 0);
    check("rst2_valid", out_valid, 0);
    check("rst2_sat", out_sat, 0);
    seen.delete();
    send(1);
    repeat (15) send(0);
    drain_wait();
    want = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0, 0, 0};
    check_seq("imp_default");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
